// File: rtl/pipe_stage_chain.sv
// Register chain of STAGES entries with per-stage stall/flush, bubble insertion
// on a split stall, and saturating bubble/flush event counters.

module pipe_stage_chain_stage #(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              flush_i,
   input  logic              hold_i,
   input  logic              bubble_i,
   input  logic              up_valid_i,
   input  logic [DATA_W-1:0] up_data_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic              bubble_ev_o,
   output logic              flush_ev_o
);
   logic              valid_d, valid_q;
   logic [DATA_W-1:0] data_d, data_q;

   // Stage 0 has bubble_i tied low, so "load input" and "copy upstream" coincide.
   always_comb begin
      valid_d = up_valid_i;
      data_d  = up_data_i;
      if (flush_i) begin
         valid_d = 1'b0;
         data_d  = '0;
      end else if (hold_i) begin
         valid_d = valid_q;
         data_d  = data_q;
      end else if (bubble_i) begin
         valid_d = 1'b0;
         data_d  = '0;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o     = valid_q;
   assign data_o      = data_q;
   assign bubble_ev_o = bubble_i & ~flush_i & ~hold_i & up_valid_i;
   assign flush_ev_o  = flush_i & valid_q;
endmodule

module pipe_stage_chain #(
   parameter int DATA_W = 32,
   parameter int STAGES = 4,
   parameter int CNT_W  = 16
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         in_valid_i,
   input  logic [DATA_W-1:0]            in_data_i,
   output logic                         in_ready_o,
   input  logic [STAGES-1:0]            stall_i,
   input  logic [STAGES-1:0]            flush_i,
   output logic                         out_valid_o,
   output logic [DATA_W-1:0]            out_data_o,
   output logic [STAGES-1:0]            stage_valid_o,
   output logic [$clog2(STAGES+1)-1:0]  occupancy_o,
   output logic [CNT_W-1:0]             bubble_cnt_o,
   output logic [CNT_W-1:0]             flush_cnt_o,
   input  logic                         cnt_clr_i
);
   localparam int OCC_W = $clog2(STAGES + 1);
   localparam int SUM_W = ((CNT_W > OCC_W) ? CNT_W : OCC_W) + 1;

   logic [STAGES-1:0]             hold, up_valid, bubble, bubble_ev, flush_ev, stage_valid;
   logic [STAGES-1:0][DATA_W-1:0] up_data, stage_data;
   logic [OCC_W-1:0]              occ, bubble_inc, flush_inc;
   logic [CNT_W-1:0]              bubble_cnt_d, bubble_cnt_q, flush_cnt_d, flush_cnt_q;

   // A stall at stage j freezes everything below it.
   always_comb begin
      hold = '0;
      for (int i = 0; i < STAGES; i++) hold[i] = |(stall_i >> i);
   end

   assign up_valid[0] = in_valid_i;
   assign up_data[0]  = in_data_i;
   assign bubble[0]   = 1'b0;

   for (genvar g = 1; g < STAGES; g++) begin : g_link
      assign up_valid[g] = stage_valid[g-1];
      assign up_data[g]  = stage_data[g-1];
      assign bubble[g]   = stall_i[g-1];
   end

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      pipe_stage_chain_stage #(.DATA_W(DATA_W)) u_stage (
         .clk_i       (clk_i),
         .reset_i     (reset_i),
         .flush_i     (flush_i[g]),
         .hold_i      (hold[g]),
         .bubble_i    (bubble[g]),
         .up_valid_i  (up_valid[g]),
         .up_data_i   (up_data[g]),
         .valid_o     (stage_valid[g]),
         .data_o      (stage_data[g]),
         .bubble_ev_o (bubble_ev[g]),
         .flush_ev_o  (flush_ev[g])
      );
   end

   always_comb begin
      occ        = '0;
      bubble_inc = '0;
      flush_inc  = '0;
      for (int i = 0; i < STAGES; i++) begin
         occ        = occ + OCC_W'(stage_valid[i]);
         bubble_inc = bubble_inc + OCC_W'(bubble_ev[i]);
         flush_inc  = flush_inc + OCC_W'(flush_ev[i]);
      end
   end

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [OCC_W-1:0] b);
      logic [SUM_W-1:0] s;
      s = SUM_W'(a) + SUM_W'(b);
      if (s > SUM_W'({CNT_W{1'b1}})) return {CNT_W{1'b1}};
      return CNT_W'(s);
   endfunction

   always_comb begin
      bubble_cnt_d = sat_add(bubble_cnt_q, bubble_inc);
      flush_cnt_d  = sat_add(flush_cnt_q, flush_inc);
      if (cnt_clr_i) begin
         bubble_cnt_d = '0;
         flush_cnt_d  = '0;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         bubble_cnt_q <= '0;
         flush_cnt_q  <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   assign in_ready_o    = ~hold[0];
   assign out_valid_o   = stage_valid[STAGES-1];
   assign out_data_o    = stage_data[STAGES-1];
   assign stage_valid_o = stage_valid;
   assign occupancy_o   = occ;
   assign bubble_cnt_o  = bubble_cnt_q;
   assign flush_cnt_o   = flush_cnt_q;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: directed table, corner sequences, random vs. model.

module tb_pipe_stage_chain;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // 4-stage DUT with narrow counters so saturation is reachable
   logic       iv4, rdy4, ov4, clr4;
   logic [7:0] d4, od4;
   logic [3:0] st4, fl4, sv4, bc4, fc4;
   logic [2:0] occ4;

   pipe_stage_chain #(.DATA_W(8), .STAGES(4), .CNT_W(4)) u4 (
      .clk_i(clk), .reset_i(rst), .in_valid_i(iv4), .in_data_i(d4), .in_ready_o(rdy4),
      .stall_i(st4), .flush_i(fl4), .out_valid_o(ov4), .out_data_o(od4),
      .stage_valid_o(sv4), .occupancy_o(occ4), .bubble_cnt_o(bc4), .flush_cnt_o(fc4),
      .cnt_clr_i(clr4));

   // single-stage DUT
   logic       iv1, rdy1, ov1, clr1, st1, fl1, sv1, occ1;
   logic [7:0] d1, od1;
   logic [3:0] bc1, fc1;

   pipe_stage_chain #(.DATA_W(8), .STAGES(1), .CNT_W(4)) u1 (
      .clk_i(clk), .reset_i(rst), .in_valid_i(iv1), .in_data_i(d1), .in_ready_o(rdy1),
      .stall_i(st1), .flush_i(fl1), .out_valid_o(ov1), .out_data_o(od1),
      .stage_valid_o(sv1), .occupancy_o(occ1), .bubble_cnt_o(bc1), .flush_cnt_o(fc1),
      .cnt_clr_i(clr1));

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
      end
   endtask

   typedef struct {
      logic [3:0] stall, flush;
      logic       iv;
      logic [7:0] id;
      logic       clr;
      logic       rdy, ov;
      logic [7:0] od;
      logic [3:0] sv;
      logic [2:0] occ;
      logic [3:0] bc, fc;
   } vec_t;

   function automatic vec_t mk(input logic [3:0] stall, flush, input logic iv,
                               input logic [7:0] id, input logic clr, rdy, ov,
                               input logic [7:0] od, input logic [3:0] sv,
                               input logic [2:0] occ, input logic [3:0] bc, fc);
      vec_t v;
      v.stall = stall; v.flush = flush; v.iv = iv; v.id = id; v.clr = clr;
      v.rdy = rdy; v.ov = ov; v.od = od; v.sv = sv; v.occ = occ; v.bc = bc; v.fc = fc;
      return v;
   endfunction

   // Behavioural model: per-edge application of the stage rules on arrays.
   bit         mv[4];
   logic [7:0] md[4];
   int         mbc, mfc;

   task automatic model_step(input logic [3:0] st, input logic [3:0] fl, input logic iv,
                             input logic [7:0] id, input logic clr);
      bit         nv[4];
      logic [7:0] nd[4];
      int         nb, nf;
      nb = 0; nf = 0;
      for (int i = 0; i < 4; i++) begin
         if (fl[i]) begin
            nv[i] = 0; nd[i] = 0;
            if (mv[i]) nf++;
         end else if ((st >> i) != 0) begin
            nv[i] = mv[i]; nd[i] = md[i];
         end else if (i == 0) begin
            nv[i] = iv; nd[i] = id;
         end else if (st[i-1]) begin
            nv[i] = 0; nd[i] = 0;
            if (mv[i-1]) nb++;
         end else begin
            nv[i] = mv[i-1]; nd[i] = md[i-1];
         end
      end
      mv = nv; md = nd;
      mbc = clr ? 0 : ((mbc + nb > 15) ? 15 : mbc + nb);
      mfc = clr ? 0 : ((mfc + nf > 15) ? 15 : mfc + nf);
   endtask

   task automatic edge1;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset;
      edge1();
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   vec_t tbl[25];

   initial begin
      logic [3:0] esv;
      int         eocc;

      iv4 = 0; d4 = 0; st4 = 0; fl4 = 0; clr4 = 0;
      iv1 = 0; d1 = 0; st1 = 0; fl1 = 0; clr1 = 0;

      //         stall    flush    iv  data   clr  rdy ov  od     sv       occ bc fc
      tbl[0]  = mk(4'h0, 4'h0, 1, 8'hA0, 0, 1, 0, 8'h00, 4'b0001, 1, 0, 0);
      tbl[1]  = mk(4'h0, 4'h0, 1, 8'hA1, 0, 1, 0, 8'h00, 4'b0011, 2, 0, 0);
      tbl[2]  = mk(4'h0, 4'h0, 1, 8'hA2, 0, 1, 0, 8'h00, 4'b0111, 3, 0, 0);
      tbl[3]  = mk(4'h0, 4'h0, 1, 8'hA3, 0, 1, 1, 8'hA0, 4'b1111, 4, 0, 0);
      tbl[4]  = mk(4'h0, 4'h0, 1, 8'hA4, 0, 1, 1, 8'hA1, 4'b1111, 4, 0, 0);
      tbl[5]  = mk(4'h0, 4'h0, 1, 8'hA5, 0, 1, 1, 8'hA2, 4'b1111, 4, 0, 0);
      tbl[6]  = mk(4'h0, 4'h0, 0, 8'h00, 0, 1, 1, 8'hA3, 4'b1110, 3, 0, 0);
      tbl[7]  = mk(4'h0, 4'h0, 0, 8'h00, 0, 1, 1, 8'hA4, 4'b1100, 2, 0, 0);
      tbl[8]  = mk(4'h0, 4'h0, 0, 8'h00, 0, 1, 1, 8'hA5, 4'b1000, 1, 0, 0);
      tbl[9]  = mk(4'h0, 4'h0, 0, 8'h00, 0, 1, 0, 8'h00, 4'b0000, 0, 0, 0);
      tbl[10] = mk(4'h0, 4'h0, 1, 8'hB0, 0, 1, 0, 8'h00, 4'b0001, 1, 0, 0);
      tbl[11] = mk(4'h0, 4'h0, 1, 8'hB1, 0, 1, 0, 8'h00, 4'b0011, 2, 0, 0);
      tbl[12] = mk(4'h0, 4'h0, 1, 8'hB2, 0, 1, 0, 8'h00, 4'b0111, 3, 0, 0);
      tbl[13] = mk(4'h0, 4'h0, 1, 8'hB3, 0, 1, 1, 8'hB0, 4'b1111, 4, 0, 0);
      tbl[14] = mk(4'h2, 4'h0, 1, 8'hC0, 0, 0, 1, 8'hB1, 4'b1011, 3, 1, 0);
      tbl[15] = mk(4'h2, 4'h0, 1, 8'hC0, 0, 0, 0, 8'h00, 4'b0011, 2, 2, 0);
      tbl[16] = mk(4'h0, 4'h0, 1, 8'hC0, 0, 1, 0, 8'h00, 4'b0111, 3, 2, 0);
      tbl[17] = mk(4'h0, 4'h0, 1, 8'hC1, 0, 1, 1, 8'hB2, 4'b1111, 4, 2, 0);
      tbl[18] = mk(4'h1, 4'h3, 1, 8'hC2, 0, 0, 1, 8'hB3, 4'b1100, 2, 2, 2);
      tbl[19] = mk(4'h0, 4'h0, 0, 8'h00, 0, 1, 1, 8'hC0, 4'b1000, 1, 2, 2);
      tbl[20] = mk(4'h0, 4'h8, 0, 8'h00, 0, 1, 0, 8'h00, 4'b0000, 0, 2, 3);
      tbl[21] = mk(4'h0, 4'h0, 0, 8'h00, 1, 1, 0, 8'h00, 4'b0000, 0, 0, 0);
      tbl[22] = mk(4'h0, 4'hF, 1, 8'hD0, 0, 1, 0, 8'h00, 4'b0000, 0, 0, 0);
      tbl[23] = mk(4'h8, 4'h0, 1, 8'hD1, 0, 0, 0, 8'h00, 4'b0000, 0, 0, 0);
      tbl[24] = mk(4'h0, 4'h0, 1, 8'hD1, 0, 1, 0, 8'h00, 4'b0001, 1, 0, 0);

      // reset state, checked while reset is still asserted
      #1;
      chk("rst_ov", 32'(ov4), 32'd0);
      chk("rst_od", 32'(od4), 32'd0);
      chk("rst_sv", 32'(sv4), 32'd0);
      chk("rst_occ", 32'(occ4), 32'd0);
      chk("rst_bc", 32'(bc4), 32'd0);
      chk("rst_fc", 32'(fc4), 32'd0);
      chk("rst_rdy", 32'(rdy4), 32'd1);
      edge1();
      edge1();
      rst = 1'b0;

      foreach (tbl[k]) begin
         st4 = tbl[k].stall; fl4 = tbl[k].flush; iv4 = tbl[k].iv;
         d4 = tbl[k].id; clr4 = tbl[k].clr;
         #1;
         chk($sformatf("tbl%0d_rdy", k), 32'(rdy4), 32'(tbl[k].rdy));
         edge1();
         chk($sformatf("tbl%0d_ov", k), 32'(ov4), 32'(tbl[k].ov));
         chk($sformatf("tbl%0d_od", k), 32'(od4), 32'(tbl[k].od));
         chk($sformatf("tbl%0d_sv", k), 32'(sv4), 32'(tbl[k].sv));
         chk($sformatf("tbl%0d_occ", k), 32'(occ4), 32'(tbl[k].occ));
         chk($sformatf("tbl%0d_bc", k), 32'(bc4), 32'(tbl[k].bc));
         chk($sformatf("tbl%0d_fc", k), 32'(fc4), 32'(tbl[k].fc));
      end
      st4 = 0; fl4 = 0; clr4 = 0;

      // saturation: 20 flushes of a valid stage 0, counter sticks at 15
      for (int k = 1; k <= 20; k++) begin
         iv4 = 1; d4 = 8'(k); fl4 = 4'h0;
         edge1();
         fl4 = 4'h1;
         edge1();
         chk($sformatf("sat_fc_%0d", k), 32'(fc4), 32'((k > 15) ? 15 : k));
      end
      fl4 = 4'h0;
      edge1();
      fl4 = 4'h1; clr4 = 1;
      edge1();
      chk("sat_clr_fc", 32'(fc4), 32'd0);
      chk("sat_clr_bc", 32'(bc4), 32'd0);
      fl4 = 0; clr4 = 0;

      // asynchronous reset mid-stream with a full pipe
      for (int k = 0; k < 4; k++) begin
         iv4 = 1; d4 = 8'hE0 + 8'(k);
         edge1();
      end
      chk("ar_full_occ", 32'(occ4), 32'd4);
      iv4 = 0; d4 = 0;
      #2;
      rst = 1'b1;
      #1;
      chk("ar_ov", 32'(ov4), 32'd0);
      chk("ar_od", 32'(od4), 32'd0);
      chk("ar_sv", 32'(sv4), 32'd0);
      chk("ar_occ", 32'(occ4), 32'd0);
      chk("ar_fc", 32'(fc4), 32'd0);
      chk("ar_rdy", 32'(rdy4), 32'd1);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         edge1();
         chk($sformatf("ar_post_ov_%0d", k), 32'(ov4), 32'd0);
      end

      // randomized stimulus against the model
      pulse_reset();
      for (int i = 0; i < 4; i++) begin mv[i] = 0; md[i] = 0; end
      mbc = 0; mfc = 0;
      for (int n = 0; n < 400; n++) begin
         st4  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         fl4  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         iv4  = 1'($urandom_range(0, 1));
         d4   = 8'($urandom);
         clr4 = ($urandom_range(0, 15) == 0);
         #1;
         chk("rnd_rdy", 32'(rdy4), 32'(st4 == 4'h0));
         model_step(st4, fl4, iv4, d4, clr4);
         edge1();
         esv = 0; eocc = 0;
         for (int i = 0; i < 4; i++) begin
            esv[i] = mv[i];
            eocc += int'(mv[i]);
         end
         chk("rnd_ov", 32'(ov4), 32'(mv[3]));
         chk("rnd_od", 32'(od4), 32'(md[3]));
         chk("rnd_sv", 32'(sv4), 32'(esv));
         chk("rnd_occ", 32'(occ4), 32'(eocc));
         chk("rnd_bc", 32'(bc4), 32'(mbc));
         chk("rnd_fc", 32'(fc4), 32'(mfc));
      end
      st4 = 0; fl4 = 0; iv4 = 0; clr4 = 0;

      // single-stage instance
      pulse_reset();
      iv1 = 1; d1 = 8'h05;
      #1;
      chk("s1_rdy", 32'(rdy1), 32'd1);
      edge1();
      chk("s1_ov", 32'(ov1), 32'd1);
      chk("s1_od", 32'(od1), 32'h05);
      st1 = 1; d1 = 8'h06;
      #1;
      chk("s1_stall_rdy", 32'(rdy1), 32'd0);
      edge1();
      chk("s1_stall_ov", 32'(ov1), 32'd1);
      chk("s1_stall_od", 32'(od1), 32'h05);
      chk("s1_stall_bc", 32'(bc1), 32'd0);
      fl1 = 1;
      edge1();
      chk("s1_flush_ov", 32'(ov1), 32'd0);
      chk("s1_flush_occ", 32'(occ1), 32'd0);
      chk("s1_flush_fc", 32'(fc1), 32'd1);
      chk("s1_flush_bc", 32'(bc1), 32'd0);
      st1 = 0; fl1 = 0; iv1 = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
